// File: rtl/jtag_mem_pkg.sv
// jtag_mem_pkg
// Shared definitions for the JTAG bridge memory responder.
// Contents:
//   - bridge opcode encodings
//   - responder FSM state type
//   - timeout read-back pattern
//   - default timeout
package jtag_mem_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/jtag_mem_if.sv
// jtag_mem_if
// Simple req/gnt/rvalid memory port.
//   MEM_REQ    request, held until MEM_GNT
//   MEM_WE     1 = write
//   MEM_ADDR   byte address (word aligned)
//   MEM_WDATA  write data
//   MEM_GNT    request accepted
//   MEM_RVALID response valid (reads and writes)
//   MEM_RDATA  read data
// Modports:
//   master  the responder side
//   slave   the memory side
interface jtag_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          MEM_REQ;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_GNT;
    logic          MEM_RVALID;
    logic [DW-1:0] MEM_RDATA;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_GNT, MEM_RVALID, MEM_RDATA
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_GNT, MEM_RVALID, MEM_RDATA
    );
endinterface

// File: rtl/jtag_mem_sync.sv
// jtag_mem_sync
// Two-flop synchronizer, W bits wide. Each bit is synchronized
// independently, so multi-bit use is only valid for quasi-static buses.
// Ports:
//   CLK    destination clock
//   RESET  synchronous, active-high
//   d      asynchronous input
//   q      synchronized output
module jtag_mem_sync #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/jtag_mem_responder.sv
// jtag_mem_responder
// System-clock side of the JTAG word-shift debug bridge. Prefetches reads
// whenever the bridge address settles to a new value while OP is READ, and
// issues one write per VALID rise while OP is WRITE.
// Ports:
//   CLK, RESET     system clock, synchronous active-high reset
//   OP, ADDR       bridge opcode / word address (TCK domain)
//   TO_MEM, VALID  bridge write data / word-complete strobe (TCK domain)
//   FROM_MEM       read data back to the bridge
//   BUSY           FSM not idle
//   ERR            sticky: reserved OP on VALID, or timeout
//   OVERRUN        sticky: VALID rise while busy
//   mem            memory port (jtag_mem_if.master)
// Build option: JTAG_MEM_TIMEOUT_EN enables the REQ/RESP timeout counter.
module jtag_mem_responder
    import jtag_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [1:0]    OP,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] TO_MEM,
    input  logic          VALID,
    output logic [DW-1:0] FROM_MEM,
    output logic          BUSY,
    output logic          ERR,
    output logic          OVERRUN,
    jtag_mem_if.master    mem
);

    state_t        state, state_nx;
    logic          valid_s, valid_q;
    logic [1:0]    op_s, op_q;
    logic [AW-1:0] a1, a2, last_addr;
    logic          eq_q, rearm;
    logic          valid_rise, addr_stable, op_settled;
    logic          rd_trig, wr_trig, go_rd, go_wr, tmo;

    jtag_mem_sync #(.W(1)) u_sync_valid (.CLK(CLK), .RESET(RESET), .d(VALID), .q(valid_s));
    jtag_mem_sync #(.W(2)) u_sync_op    (.CLK(CLK), .RESET(RESET), .d(OP),    .q(op_s));

    assign valid_rise  = valid_s & ~valid_q;
    assign addr_stable = eq_q && (a1 == a2);
    // Holding off reads until the synced OP has settled keeps the rearm
    // set by an OP change from being cleared by the same read it enables.
    assign op_settled  = (op_s == op_q);
    assign rd_trig     = (op_s == OP_READ) && op_settled && addr_stable &&
                         ((a2 != last_addr) || rearm);
    assign wr_trig     = valid_rise && (op_s == OP_WRITE);
    assign go_wr       = (state == ST_IDLE) && wr_trig;
    assign go_rd       = (state == ST_IDLE) && !wr_trig && rd_trig;

`ifdef JTAG_MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge CLK) begin
        if (RESET || state == ST_IDLE) tmo_cnt <= '0;
        else                           tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo = (state != ST_IDLE) && (tmo_cnt == CW'(TIMEOUT));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (go_wr || go_rd) state_nx = ST_REQ;
            ST_REQ: begin
                if (tmo)              state_nx = ST_IDLE;
                else if (mem.MEM_GNT) state_nx = ST_RESP;
            end
            ST_RESP: if (tmo || mem.MEM_RVALID) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign mem.MEM_REQ = (state == ST_REQ);
    assign BUSY        = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a1            <= '0;
            a2            <= '0;
            eq_q          <= 1'b0;
            valid_q       <= 1'b0;
            op_q          <= OP_NOP;
            last_addr     <= '0;
            rearm         <= 1'b1;
            mem.MEM_ADDR  <= '0;
            mem.MEM_WE    <= 1'b0;
            mem.MEM_WDATA <= '0;
            FROM_MEM      <= '0;
            ERR           <= 1'b0;
            OVERRUN       <= 1'b0;
        end else begin
            a1      <= ADDR;
            a2      <= a1;
            eq_q    <= (a1 == a2);
            valid_q <= valid_s;
            op_q    <= op_s;

            if (go_wr) begin
                mem.MEM_ADDR  <= a2;
                mem.MEM_WE    <= 1'b1;
                mem.MEM_WDATA <= TO_MEM;
            end else if (go_rd) begin
                mem.MEM_ADDR <= a2;
                mem.MEM_WE   <= 1'b0;
                last_addr    <= a2;
            end

            if (!op_settled) rearm <= 1'b1;
            else if (go_rd)  rearm <= 1'b0;

            if (tmo) begin
`ifdef JTAG_MEM_TIMEOUT_EN
                if (!mem.MEM_WE) FROM_MEM <= DW'(DEADBEEF);
`endif
                ERR <= 1'b1;
            end else if (state == ST_RESP && mem.MEM_RVALID && !mem.MEM_WE) begin
                FROM_MEM <= mem.MEM_RDATA;
            end

            if (valid_rise) begin
                if (state != ST_IDLE)     OVERRUN <= 1'b1;
                else if (op_s == OP_RSVD) ERR     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtag_mem_responder.sv
// tb_jtag_mem_responder
// Directed scenarios followed by randomized bridge operations, checked
// against a transaction-level model of the responder kept in the bench.
module tb_jtag_mem_responder;
    import jtag_mem_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [1:0]    OP;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] TO_MEM;
    logic          VALID;
    logic [DW-1:0] FROM_MEM;
    logic          BUSY, ERR, OVERRUN;

    jtag_mem_if #(.AW(AW), .DW(DW)) mem ();

    jtag_mem_responder #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .OP(OP), .ADDR(ADDR), .TO_MEM(TO_MEM),
        .VALID(VALID), .FROM_MEM(FROM_MEM), .BUSY(BUSY), .ERR(ERR),
        .OVERRUN(OVERRUN), .mem(mem)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    acc_t          obs_q[$];
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    int            gnt_lat, rsp_lat;
    bit            gnt_block, rsp_never;

    int n_cmp = 0;
    int n_bad = 0;

    // transaction-level model state
    logic [1:0]    cur_op;
    logic [AW-1:0] m_last;
    bit            m_rearm, m_err, m_ovr;
    logic [DW-1:0] m_from;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory slave with configurable grant / response latency
    initial begin
        mem.MEM_GNT    = 1'b0;
        mem.MEM_RVALID = 1'b0;
        mem.MEM_RDATA  = '0;
        forever begin
            @(negedge CLK);
            if (mem.MEM_REQ && !RESET) begin
                acc_t a;
                for (int i = 0; i < gnt_lat; i++) @(negedge CLK);
                while (gnt_block) @(negedge CLK);
                if (mem.MEM_REQ) begin
                    a.we    = mem.MEM_WE;
                    a.addr  = mem.MEM_ADDR;
                    a.wdata = mem.MEM_WDATA;
                    obs_q.push_back(a);
                    if (a.we) mem_model[a.addr] = a.wdata;
                    mem.MEM_GNT = 1'b1;
                    @(negedge CLK);
                    mem.MEM_GNT = 1'b0;
                    for (int i = 0; i < rsp_lat; i++) @(negedge CLK);
                    if (!rsp_never) begin
                        mem.MEM_RDATA  = a.we ? '0 : mem_rd(a.addr);
                        mem.MEM_RVALID = 1'b1;
                        @(negedge CLK);
                        mem.MEM_RVALID = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic settle();
        int n;
        n = 0;
        repeat (10) @(negedge CLK);
        while (BUSY && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("idle_bound", (n < 400), 1);
        repeat (4) @(negedge CLK);
    endtask

    task automatic set_op(input logic [1:0] op);
        if (op != cur_op) begin
            OP      = op;
            cur_op  = op;
            m_rearm = 1'b1;
            repeat (6) @(negedge CLK);
        end
    endtask

    task automatic pulse_valid();
        VALID = 1'b1;
        repeat (3) @(negedge CLK);
        VALID = 1'b0;
    endtask

    task automatic expect_acc(input string tag, input int n, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        acc_t a;
        check({tag, "_count"}, obs_q.size(), n);
        if (n == 1 && obs_q.size() > 0) begin
            a = obs_q.pop_front();
            check({tag, "_we"}, a.we, we);
            check({tag, "_addr"}, a.addr, addr);
            if (we) check({tag, "_wdata"}, a.wdata, wd);
        end
        obs_q.delete();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_from_mem"}, FROM_MEM, m_from);
        check({tag, "_err"}, ERR, m_err);
        check({tag, "_overrun"}, OVERRUN, m_ovr);
        check({tag, "_busy"}, BUSY, 0);
    endtask

    task automatic do_reset();
        OP     = OP_NOP;
        cur_op = OP_NOP;
        VALID  = 1'b0;
        RESET  = 1'b1;
        repeat (4) @(negedge CLK);
        RESET   = 1'b0;
        m_last  = '0;
        m_rearm = 1'b1;
        m_from  = '0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
        obs_q.delete();
        @(negedge CLK);
        check("req_after_reset", mem.MEM_REQ, 0);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a);
        bit exp;
        if (cur_op != OP_READ) begin
            ADDR = a;
            repeat (6) @(negedge CLK);
            set_op(OP_READ);
        end else begin
            ADDR = a;
        end
        exp = m_rearm || (a != m_last);
        settle();
        if (exp) begin
            m_last  = a;
            m_rearm = 1'b0;
            m_from  = mem_rd(a);
        end
        expect_acc(tag, exp ? 1 : 0, 1'b0, a, '0);
        check_flags(tag);
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_op(OP_WRITE);
        ADDR   = a;
        TO_MEM = d;
        repeat (6) @(negedge CLK);
        pulse_valid();
        settle();
        expect_acc(tag, 1, 1'b1, a, d);
        check_flags(tag);
    endtask

    task automatic do_other(input string tag, input logic [1:0] op);
        set_op(op);
        pulse_valid();
        settle();
        if (op == OP_RSVD) m_err = 1'b1;
        expect_acc(tag, 0, 1'b0, '0, '0);
        check_flags(tag);
    endtask

    initial begin
        int n;
        int sel;
        RESET     = 1'b1;
        OP        = OP_NOP;
        ADDR      = '0;
        TO_MEM    = '0;
        VALID     = 1'b0;
        gnt_lat   = 0;
        rsp_lat   = 0;
        gnt_block = 1'b0;
        rsp_never = 1'b0;
        cur_op    = OP_NOP;

        do_reset();
        check("rst_from_mem", FROM_MEM, 0);
        check("rst_mem_we", mem.MEM_WE, 0);
        check("rst_mem_addr", mem.MEM_ADDR, 0);
        check("rst_mem_wdata", mem.MEM_WDATA, 0);
        check("rst_busy", BUSY, 0);
        check("rst_err", ERR, 0);
        check("rst_overrun", OVERRUN, 0);

        // first read: 2-cycle response latency, must land within 32 TCK
        mem_model[32'h100] = 32'h1234_5678;
        rsp_lat = 2;
        ADDR    = 32'h100;
        repeat (6) @(negedge CLK);
        OP      = OP_READ;
        cur_op  = OP_READ;
        n = 0;
        while (FROM_MEM !== 32'h1234_5678 && n < 96) begin
            @(negedge CLK);
            n++;
        end
        check("rd100_within_32tck", (n < 96), 1);
        m_last  = 32'h100;
        m_rearm = 1'b0;
        m_from  = 32'h1234_5678;
        settle();
        expect_acc("rd100", 1, 1'b0, 32'h100, '0);
        check_flags("rd100");

        rsp_lat = 0;
        do_write("wr200", 32'h200, 32'hCAFE_F00D);

        do_read("rd100b", 32'h100);
        do_read("rd104", 32'h104);
        do_read("rd108", 32'h108);
        do_read("rd108_dup", 32'h108);

        // second VALID while the first write is stuck waiting for grant
        gnt_block = 1'b1;
        set_op(OP_WRITE);
        ADDR   = 32'h300;
        TO_MEM = 32'h0BAD_CAFE;
        repeat (6) @(negedge CLK);
        pulse_valid();
        repeat (4) @(negedge CLK);
        check("ovr_busy", BUSY, 1);
        TO_MEM = 32'h1111_2222;
        pulse_valid();
        repeat (6) @(negedge CLK);
        m_ovr = 1'b1;
        check("ovr_flag", OVERRUN, 1);
        gnt_block = 1'b0;
        settle();
        expect_acc("ovr", 1, 1'b1, 32'h300, 32'h0BAD_CAFE);
        check_flags("ovr");

        do_other("rsvd", OP_RSVD);
        do_other("nop", OP_NOP);

`ifdef JTAG_MEM_TIMEOUT_EN
        rsp_never = 1'b1;
        ADDR = 32'h500;
        repeat (6) @(negedge CLK);
        set_op(OP_READ);
        settle();
        m_last  = 32'h500;
        m_rearm = 1'b0;
        m_from  = DEADBEEF;
        m_err   = 1'b1;
        expect_acc("tmo", 1, 1'b0, 32'h500, '0);
        check_flags("tmo");
        rsp_never = 1'b0;
`endif

        do_reset();
        for (int it = 0; it < 40; it++) begin
            logic [AW-1:0] a;
            gnt_lat = $urandom_range(0, 3);
            rsp_lat = $urandom_range(0, 3);
            a   = 32'h100 + 32'(4 * $urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel <= 4)      do_read("rnd_rd", a);
            else if (sel <= 7) do_write("rnd_wr", a, $urandom);
            else if (sel == 8) do_other("rnd_nop", OP_NOP);
            else               do_other("rnd_rsvd", OP_RSVD);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_mem_responder.md
# jtag_mem_responder

Memory-side responder for the JTAG word-shift debug bridge. It runs on the system clock and takes the bridge's TCK-domain request signals (OP, ADDR, TO_MEM, VALID). It performs single-word writes and prefetching reads on a simple req/gnt/rvalid memory port. Read data is returned on FROM_MEM before the bridge loads its shift register. It sits between the BSCAN-driven bridge and the system memory interconnect.

## Interface
- AW, 32, address width (byte address, word-aligned)
- DW, 32, data width
- TIMEOUT, 255, max CLK cycles waiting for MEM_GNT/MEM_RVALID (only with timeout feature)
- CLK  in  1  system clock; must be ≥ 3× TCK frequency
- RESET  in  1  reset, synchronous, active-high
- OP  in  2  bridge opcode (TCK domain): 00 NOP, 01 READ, 10 WRITE, 11 reserved
- ADDR  in  AW  bridge word address (TCK domain, quasi-static)
- TO_MEM  in  DW  write data (TCK domain, stable ≥ 32 TCK after VALID rise)
- VALID  in  1  word-complete strobe (TCK domain, high ≥ 1 TCK)
- FROM_MEM  out  DW  read data to bridge, held until next completed read
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  AW  memory address
- MEM_WDATA  out  DW  memory write data
- MEM_GNT  in  1  request accepted
- MEM_RVALID  in  1  response valid (reads and writes)
- MEM_RDATA  in  DW  read data
- BUSY  out  1  FSM not in IDLE
- ERR  out  1  sticky: reserved OP on VALID, or timeout
- OVERRUN  out  1  sticky: VALID rise while BUSY (request dropped)

## Operation
- VALID passes through a 2-flop synchronizer. A rise is detected on stage 2 vs stage 3.
- OP is 2-flop synchronized. ADDR is sampled every CLK into a2 and a1. ADDR counts as stable when a1 == a2 for 2 consecutive cycles.
- Read prefetch: synced OP == READ, ADDR stable, and stable value ≠ last_addr (or rearm flag set) -> issue read, last_addr <= value, clear rearm.
- Rearm is set on reset and whenever OP changes. This guarantees a fresh fetch after each CAPTURE.
- Write: VALID rise with synced OP == WRITE -> issue write of TO_MEM to the stable ADDR.
- VALID rise with OP 11 -> ERR set, no access. VALID rise with OP 00 or 01 -> no access.
- FSM states:
  - IDLE -> REQ on a trigger.
  - REQ holds MEM_REQ until MEM_GNT, then -> RESP.
  - RESP waits MEM_RVALID. On a read, FROM_MEM <= MEM_RDATA. Then -> IDLE.
- If a write trigger and a read trigger coincide in IDLE, the write wins. The read trigger stays pending, since the stable-change condition persists.
- VALID rise while not IDLE -> OVERRUN set, event dropped.
- MEM_ADDR, MEM_WE and MEM_WDATA are registered at IDLE->REQ and held through RESP.
- Reset: FROM_MEM 0, MEM_REQ 0, MEM_WE 0, MEM_ADDR 0, MEM_WDATA 0, BUSY 0, ERR 0, OVERRUN 0, state IDLE, last_addr 0, rearm 1.
- Reset mid-transaction abandons the access. No MEM_REQ is asserted in the cycle after reset.

## Timing
- Trigger detected in cycle t -> MEM_REQ high at t+1.
- Read data visible on FROM_MEM the cycle after MEM_RVALID.
- Zero-wait memory: VALID rise to MEM_REQ takes 4 CLK. ADDR change to FROM_MEM update takes ≤ 7 CLK + memory latency.
- Budget: FROM_MEM must settle within 32 TCK of an ADDR change. This is guaranteed for memory latency ≤ 80 CLK at the 3× ratio.
- MEM_REQ drops the cycle after MEM_GNT.

## Configuration
- JTAG_MEM_TIMEOUT_EN defined: an 8+ bit counter runs in REQ/RESP. When it reaches TIMEOUT:
  - return to IDLE
  - FROM_MEM <= 32'hDEAD_BEEF on reads
  - set ERR
- Not defined: no counter, REQ/RESP wait indefinitely, and ERR is set only by reserved OP.

## Structure
- Shared package jtag_mem_pkg holds:
  - OP encodings (OP_NOP/OP_READ/OP_WRITE/OP_RSVD)
  - FSM state typedef
  - DEADBEEF constant
  - default TIMEOUT
- Sub-module jtag_mem_sync: parameterized 2-flop synchronizer, used for VALID and OP.

## Test plan
- Reset, then OP = READ, ADDR = 0x100, memory returns 0x12345678 with 2-cycle latency -> one read to 0x100; FROM_MEM = 0x12345678 before 32 TCK elapse.
- OP = WRITE, ADDR = 0x200, TO_MEM = 0xCAFEF00D, VALID pulse of 1 TCK -> exactly one write, MEM_WDATA = 0xCAFEF00D, MEM_ADDR = 0x200.
- Read with ADDR stepping 0x100 -> 0x104 -> 0x108 -> three reads in order; no duplicate for an unchanged address.
- Second VALID rise while MEM_GNT is held low -> OVERRUN = 1, exactly one access issued.
- VALID with OP = 11 -> ERR = 1, MEM_REQ stays 0.
- JTAG_MEM_TIMEOUT_EN, TIMEOUT = 16, MEM_RVALID never asserted on a read -> after 16 cycles FSM is IDLE, FROM_MEM = 0xDEADBEEF, ERR = 1.
